// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, frame geometry, command bytes.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 9;  // 8 data bits + odd parity

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RTS   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] ACK         = 8'hFA;

    // PS/2 uses odd parity: the parity bit makes the 9-bit total odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the device-driven PS/2 clock; emits a falling-edge pulse.
// Latency: fall_edge_o pulses FILTER_LEN+1 cycles after the pin falls.
// Backpressure: none; free-running, shared with the receive path.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2c_i,
    output logic fclk_o,
    output logic fall_edge_o
);

    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic                  fall_q, fall_d;

    // Shift the raw pin in; the filtered level only moves on a unanimous history.
    always_comb begin
        filt_d = {ps2c_i, filt_q[FILTER_LEN-1:1]};
        fclk_d = fclk_q;
        if (&filt_q) begin
            fclk_d = 1'b1;
        end else if (~|filt_q) begin
            fclk_d = 1'b0;
        end
        fall_d = fclk_q & ~fclk_d;
    end

    // Filter state; idles as a released (high) clock line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q <= '1;
            fclk_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fclk_q <= fclk_d;
            fall_q <= fall_d;
        end
    end

    assign fclk_o      = fclk_q;
    assign fall_edge_o = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter (RTS, start, 8 data, odd parity, stop, ACK).
// Latency: RTS_CYCLES of request-to-send, then 11 device clock falls; done tick on the ACK fall.
// Backpressure: wr_ps2 only accepted while tx_idle; ignored otherwise. Watchdog under PS2_TX_TIMEOUT_EN.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int CNT_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

    logic [2:0]                state_q, state_d;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]                n_q, n_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      done_q, done_d;
    logic [1:0]                dsync_q;
    logic                      fall_edge;
    logic                      fclk_unused;
    logic                      timeout;
    logic                      c_low, d_low;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filt (
        .clk_i      (clk),
        .rst_i      (rst),
        .ps2c_i     (ps2c),
        .fclk_o     (fclk_unused),
        .fall_edge_o(fall_edge)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_active;

    assign wd_active = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign timeout   = wd_active && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts idle time between device clock falls; held at 0 outside
    // the device-clocked states, which also clears it on entry to START.
    always_comb begin
        wd_d = '0;
        if (wd_active && !fall_edge && !timeout) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
    wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // Frame sequencer: next-state, shift register, bit count and status.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_ps2) begin
                    frame_d = {odd_parity(din), din};
                    err_d   = 1'b0;
                    cnt_d   = CNT_W'(RTS_CYCLES - 1);
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                if (cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_START: begin
                if (fall_edge) begin
                    n_d     = 4'(PS2_FRAME_BITS - 1);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    frame_d = {1'b0, frame_q[PS2_FRAME_BITS-1:1]};
                    if (n_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end
            end
            ST_STOP: begin
                // Device pulls data low during this clock to ACK; high means NACK.
                if (fall_edge) begin
                    done_d  = 1'b1;
                    err_d   = err_q | dsync_q[1];
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b0;
        end
    end

    // Sequencer registers; async reset drops the line drivers immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Two-flop synchronizer on the data pin for the ACK sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsync_q <= 2'b11;
        end else begin
            dsync_q <= {dsync_q[0], ps2d};
        end
    end

    // Open-drain drivers decoded straight from state so reset releases them at once.
    assign c_low = (state_q == ST_RTS);
    assign d_low = (state_q == ST_RTS) || (state_q == ST_START) ||
                   ((state_q == ST_DATA) && !frame_q[0]);

    assign ps2c = c_low ? 1'b0 : 1'bz;
    assign ps2d = d_low ? 1'b0 : 1'bz;

    assign tx_idle      = (state_q == ST_IDLE);
    assign tx_done_tick = done_q;
    assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 device on open-drain lines.
// Latency: device clock half-period HALF cycles (faster than 12.5 kHz to keep runs short).
// Backpressure: n/a.
module tb_ps2_tx;

    localparam int HALF = 50;

    logic       clk;
    logic       rst;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;
    logic       dev_c_low;
    logic       dev_d_low;
    wire        ps2c;
    wire        ps2d;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    ps2_tx #(
        .RTS_CYCLES    (5000),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) done_cnt++;
    end

    task automatic do_write(input logic [7:0] b);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    // Device model: waits out RTS, then issues nclk clocks, sampling data in
    // each high phase before the fall. ACK is driven low across the 11th clock.
    task automatic dev_frame(input bit ack, input bit glitch, input int nclk,
                             output logic [10:0] bits, output int rts_len);
        int guard;
        bits    = '0;
        rts_len = 0;
        guard   = 0;
        while (ps2c !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (ps2c !== 1'b0) begin
            total_cnt++;
            $display("FAIL rts_seen: ps2c=%b required 0", ps2c);
            return;
        end
        while (ps2c === 1'b0 && rts_len < 20000) begin
            rts_len++;
            @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < nclk; k++) begin
            bits[k] = ps2d;
            if (k == 10 && ack) dev_d_low = 1'b1;
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            if (glitch && k == 4) begin
                repeat (10) @(negedge clk);
                dev_c_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (HALF - 13) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_d_low = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (tx_idle !== 1'b1) $display("FAIL reset_idle: got %b required 1", tx_idle); else pass_cnt++;
        total_cnt++;
        if (tx_done_tick !== 1'b0) $display("FAIL reset_done: got %b required 0", tx_done_tick); else pass_cnt++;
        total_cnt++;
        if (tx_err !== 1'b0) $display("FAIL reset_err: got %b required 0", tx_err); else pass_cnt++;
        total_cnt++;
        if ({ps2c, ps2d} !== 2'b11) $display("FAIL reset_lines: got %b required 11", {ps2c, ps2d}); else pass_cnt++;
    endtask

    task automatic test_write_ed();
        logic [10:0] bits;
        int          rts;
        int          d0;
        d0 = done_cnt;
        do_write(8'hED);
        dev_frame(1'b1, 1'b0, 11, bits, rts);
        total_cnt++;
        if (rts != 5000) $display("FAIL ed_rts_len: got %0d required 5000", rts); else pass_cnt++;
        total_cnt++;
        if (bits !== 11'b1_1_11101101_0) $display("FAIL ed_bits: got %b required %b", bits, 11'b1_1_11101101_0); else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL ed_done: got %0d required 1", done_cnt - d0); else pass_cnt++;
        total_cnt++;
        if (tx_err !== 1'b0) $display("FAIL ed_err: got %b required 0", tx_err); else pass_cnt++;
        total_cnt++;
        if (tx_idle !== 1'b1) $display("FAIL ed_idle: got %b required 1", tx_idle); else pass_cnt++;
    endtask

    task automatic test_write_zero();
        logic [10:0] bits;
        int          rts;
        int          d0;
        d0 = done_cnt;
        do_write(8'h00);
        dev_frame(1'b1, 1'b0, 11, bits, rts);
        total_cnt++;
        if (bits !== 11'b1_1_00000000_0) $display("FAIL zero_bits: got %b required %b", bits, 11'b1_1_00000000_0); else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL zero_done: got %0d required 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_nack_then_clear();
        logic [10:0] bits;
        int          rts;
        int          d0;
        d0 = done_cnt;
        do_write(8'hED);
        dev_frame(1'b0, 1'b0, 11, bits, rts);
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL nack_done: got %0d required 1", done_cnt - d0); else pass_cnt++;
        total_cnt++;
        if (tx_err !== 1'b1) $display("FAIL nack_err: got %b required 1", tx_err); else pass_cnt++;
        do_write(8'hFF);
        total_cnt++;
        if (tx_err !== 1'b0) $display("FAIL clear_on_wr: got %b required 0", tx_err); else pass_cnt++;
        dev_frame(1'b1, 1'b0, 11, bits, rts);
        total_cnt++;
        if (bits !== 11'b1_1_11111111_0) $display("FAIL ff_bits: got %b required %b", bits, 11'b1_1_11111111_0); else pass_cnt++;
        total_cnt++;
        if (tx_err !== 1'b0) $display("FAIL ff_err: got %b required 0", tx_err); else pass_cnt++;
    endtask

    task automatic test_ignore_wr();
        logic [10:0] bits;
        int          rts;
        int          d0;
        d0 = done_cnt;
        do_write(8'hED);
        fork
            dev_frame(1'b1, 1'b0, 11, bits, rts);
            begin
                repeat (5300) @(negedge clk);
                din    = 8'hAA;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        total_cnt++;
        if (bits !== 11'b1_1_11101101_0) $display("FAIL ignore_bits: got %b required %b", bits, 11'b1_1_11101101_0); else pass_cnt++;
        repeat (20) @(negedge clk);
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL ignore_done: got %0d required 1", done_cnt - d0); else pass_cnt++;
        total_cnt++;
        if ({tx_idle, ps2c} !== 2'b11) $display("FAIL ignore_no_requeue: idle,ps2c=%b required 11", {tx_idle, ps2c}); else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic [10:0] bits;
        int          rts;
        int          d0;
        d0 = done_cnt;
        do_write(8'hEE);
        dev_frame(1'b1, 1'b1, 11, bits, rts);
        total_cnt++;
        if (bits !== 11'b1_1_11101110_0) $display("FAIL glitch_bits: got %b required %b", bits, 11'b1_1_11101110_0); else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL glitch_done: got %0d required 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        int          rts;
        do_write(8'h55);
        dev_frame(1'b0, 1'b0, 2, bits, rts);
        total_cnt++;
        if ({tx_idle, ps2d} !== 2'b00) $display("FAIL mid_pre: idle,ps2d=%b required 00", {tx_idle, ps2d}); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({ps2c, ps2d, tx_idle} !== 3'b111) $display("FAIL mid_rst: ps2c,ps2d,idle=%b required 111", {ps2c, ps2d, tx_idle}); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({tx_idle, tx_err, ps2c, ps2d} !== 4'b1011) $display("FAIL mid_after: idle,err,c,d=%b required 1011", {tx_idle, tx_err, ps2c, ps2d}); else pass_cnt++;
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout();
        logic [10:0] bits;
        int          rts;
        int          d0;
        d0 = done_cnt;
        do_write(8'hED);
        dev_frame(1'b0, 1'b0, 5, bits, rts);
        repeat (500) @(negedge clk);
        total_cnt++;
        if ({tx_idle, tx_err} !== 2'b00) $display("FAIL to_early: idle,err=%b required 00", {tx_idle, tx_err}); else pass_cnt++;
        repeat (600) @(negedge clk);
        total_cnt++;
        if ({tx_idle, tx_err, ps2c, ps2d} !== 4'b1111) $display("FAIL to_fire: idle,err,c,d=%b required 1111", {tx_idle, tx_err, ps2c, ps2d}); else pass_cnt++;
        total_cnt++;
        if (done_cnt != d0) $display("FAIL to_no_done: got %0d required 0", done_cnt - d0); else pass_cnt++;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        wr_ps2    = 1'b0;
        din       = 8'h00;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        test_reset();
        test_write_ed();
        test_write_zero();
        test_nack_then_clear();
        test_ignore_wr();
        test_glitch();
        test_reset_mid();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte, e.g. 0xED set-LEDs or 0xFF reset, from the FPGA to the keyboard.
- Clocking is device-driven, with host request-to-send (RTS), open-drain lines, odd parity and device acknowledge.
- Shares the ps2c/ps2d pins with the existing keyboard receive path. The receive path must only be enabled while tx_idle=1.

Parameters:
- RTS_CYCLES, 5000: clk cycles that ps2c is held low for RTS (100 us at 50 MHz).
- FILTER_LEN, 8: depth of the ps2c glitch-filter shift register.
- TIMEOUT_CYCLES, 1000000: maximum clk cycles between device falling edges (20 ms at 50 MHz). Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- wr_ps2  in  1  start request. Sampled only in IDLE.
- din  in  8  command byte. Latched on an accepted wr_ps2.
- ps2c  inout  1  PS/2 clock. Open-drain: either driven 0 or released to 'z'.
- ps2d  inout  1  PS/2 data. Open-drain: either driven 0 or released to 'z'.
- tx_idle  out  1  high in IDLE.
- tx_done_tick  out  1  one-cycle pulse when a frame completes.
- tx_err  out  1  sticky error flag (NACK or timeout). Cleared by the next accepted wr_ps2.

Behaviour:
- Reset values:
  - State IDLE.
  - tx_idle=1, tx_done_tick=0, tx_err=0.
  - Both lines released.
  - Filter register all ones, filtered clock=1, all counters 0.
- Reset mid-frame: the lines are released asynchronously and the block returns to IDLE.
- Glitch filter:
  - ps2c is shifted into a FILTER_LEN-bit register every clk.
  - The filtered clock becomes 1 when the register is all ones and 0 when it is all zeros; otherwise it holds.
  - fall_edge is a one-cycle pulse when the filtered clock goes 1->0.
  - fall_edge latency: FILTER_LEN+1 cycles after the pin falls.
- Frame register: 9 bits {par, din}, with par = ~^din (odd parity). A bit count n tracks progress.
- IDLE:
  - Both lines released.
  - wr_ps2=1: latch the frame, clear tx_err, load the counter with RTS_CYCLES-1, go to RTS on the next edge. tx_idle drops in the same cycle the state changes.
  - wr_ps2 in any other state is ignored; no queueing.
- RTS:
  - Drive ps2c=0 and ps2d=0; the counter decrements each cycle.
  - When the counter reaches 0, go to START.
- START:
  - Release ps2c; keep ps2d=0 (start bit).
  - On fall_edge, go to DATA with n=8.
- DATA:
  - ps2d is driven 0 when frame[0]=0 and released when frame[0]=1.
  - On fall_edge: shift the frame right by one; if n==0 go to STOP, else n=n-1.
  - This transfers 9 bits, LSB first, parity last.
- STOP:
  - Release ps2d (stop bit).
  - On the next fall_edge (device ACK clock), sample ps2d and go to IDLE.
  - In the same cycle, pulse tx_done_tick; set tx_err if the sampled ps2d=1 (NACK).
- Frame count: 11 device falling edges per frame (start edge + 9 data/parity + ACK).
- Simultaneous events: fall_edge during RTS is ignored.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- Enabled:
  - A watchdog counter runs in START, DATA and STOP, resets on every fall_edge, and resets on entry to START.
  - When it reaches TIMEOUT_CYCLES-1: release both lines, set tx_err, go to IDLE.
  - No tx_done_tick is issued on timeout.
- Disabled:
  - No watchdog logic is present.
  - The FSM waits indefinitely for device clocks.
  - tx_err is set by NACK only.

Decomposition:
- Shared package ps2_pkg:
  - state encoding: IDLE, RTS, START, DATA, STOP.
  - PS2_FRAME_BITS=9.
  - Command constants: CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF, ACK=8'hFA.
- One natural sub-module: ps2_clk_filter (shift register, filtered clock, fall_edge). It is reusable by the receive path.

Test Plan:
- Write 0xED with a device model clocking at 12.5 kHz that ACKs:
  - ps2c is low for exactly 5000 cycles.
  - Device reads bits 1,0,1,1,0,1,1,1, parity 1.
  - tx_done_tick pulses once; tx_err=0; tx_idle returns to 1.
- Write 0x00:
  - Parity bit=1; all data bits 0; ps2d is released at STOP.
- Device withholds ACK (ps2d high on the 11th edge):
  - tx_done_tick=1 and tx_err=1.
  - Next write 0xFF clears tx_err.
- Pulse wr_ps2 with 0xAA during DATA of a 0xED frame:
  - Ignored; only 0xED is transmitted; exactly one done tick.
- 3-cycle glitch on ps2c during DATA:
  - No fall_edge; the bit position is unchanged.
- Assert rst mid-DATA:
  - Both lines released within the same cycle; tx_idle=1.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, the device stops clocking after 4 bits:
  - After 1000 cycles, lines released, tx_err=1, no done tick.
